// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE core pipeline: state encoding for the
// memory stage, datapath widths and the memWrite request codes used by p3.
package simple_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;

    // Memory request codes, same encoding p3 drives on its memWrite field
    localparam logic [1:0] MEM_NONE  = 2'd0;
    localparam logic [1:0] MEM_READ  = 2'd1;
    localparam logic [1:0] MEM_WRITE = 2'd2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } p4_state_t;

endpackage

// File: rtl/p4_mem_if.sv
// Data-memory port of the p4 stage: request (address, write data, strobes)
// out of the stage, completion (read data, ready) back into it.
interface p4_mem_if;
    import simple_pkg::*;

    logic [DATA_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic              memRead;
    logic              memWrite;
    logic [DATA_W-1:0] memRdata;
    logic              memReady;

    modport master (
        output memAddr, memWdata, memRead, memWrite,
        input  memRdata, memReady
    );

    modport slave (
        input  memAddr, memWdata, memRead, memWrite,
        output memRdata, memReady
    );

endinterface

// File: rtl/p4_mem.sv
// SIMPLE core stage 4: data-memory access with a ready handshake and a
// timeout abort, producing the register-file write-back triple and the
// upstream stall while an access is outstanding.
module p4_mem
    import simple_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] aluOutput,
    input  logic              writeRegp3,
    input  logic [REG_W-1:0]  regAddressp3,
    input  logic [DATA_W-1:0] Address,
    input  logic [DATA_W-1:0] storeData,
    input  logic              readEnable,
    input  logic              writeEnable,
    p4_mem_if.master          mem,
    output logic              stall,
    output logic              memError,
    output logic              writeRegp4,
    output logic [REG_W-1:0]  regAddressp4,
    output logic [DATA_W-1:0] writeDatap4
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    p4_state_t         state_q, state_d;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [REG_W-1:0]  reg_q;
    logic [1:0]        type_q;
    logic [CNT_W-1:0]  cnt_q;

    logic accept, done, abort;
    logic [1:0] req_code;

    // A simultaneous read+write request is demoted to a read
    assign req_code = readEnable ? MEM_READ : MEM_WRITE;

    // State register; reset drops any outstanding access at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and memory-port outputs; ready beats timeout on the same edge
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        done         = 1'b0;
        abort        = 1'b0;
        stall        = 1'b0;
        mem.memRead  = 1'b0;
        mem.memWrite = 1'b0;
        mem.memAddr  = '0;
        mem.memWdata = '0;
        case (state_q)
            IDLE: begin
                if (readEnable || writeEnable) begin
                    accept  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                stall        = 1'b1;
                mem.memRead  = (type_q == MEM_READ);
                mem.memWrite = (type_q == MEM_WRITE);
                mem.memAddr  = addr_q;
                mem.memWdata = wdata_q;
                if (mem.memReady) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding registers, timeout counter and write-back outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            reg_q        <= '0;
            type_q       <= MEM_NONE;
            cnt_q        <= '0;
            memError     <= 1'b0;
            writeRegp4   <= 1'b0;
            regAddressp4 <= '0;
            writeDatap4  <= '0;
        end else begin
            memError <= 1'b0;
            if (accept) begin
                addr_q     <= Address;
                wdata_q    <= storeData;
                reg_q      <= regAddressp3;
                type_q     <= req_code;
                cnt_q      <= '0;
                writeRegp4 <= 1'b0;
                memError   <= readEnable & writeEnable;
            end else if (state_q == IDLE) begin
                // ALU op: one-cycle passthrough; data only moves with a write
                writeRegp4   <= writeRegp3;
                regAddressp4 <= regAddressp3;
                if (writeRegp3) writeDatap4 <= aluOutput;
            end else if (done) begin
                if (type_q == MEM_READ) begin
                    writeDatap4  <= mem.memRdata;
                    writeRegp4   <= 1'b1;
                    regAddressp4 <= reg_q;
                end else begin
                    writeRegp4 <= 1'b0;
                end
            end else begin
                writeRegp4 <= 1'b0;
                cnt_q      <= cnt_q + 1'b1;
                if (abort) memError <= 1'b1;
            end
        end
    end

endmodule

// File: doc/p4_mem.md
Name: p4_mem

Overview:
Fourth pipeline stage of the SIMPLE core, directly downstream of p3. It consumes p3's registered ALU result, write-back control and memory request (address, store data, read/write enables) and performs the data-memory access. The memory is variable-latency and uses a ready handshake. The stage produces the write-back triple (enable, register address, data) for the register file, and a stall that freezes p1–p3 while an access is outstanding.

Parameters:
TIMEOUT, 15, cycles in ACCESS without memReady before the access is aborted (1..255)
CNT_W, 8, width of the timeout counter

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
aluOutput  in  16  ALU result from p3
writeRegp3  in  1  register write-back requested
regAddressp3  in  3  destination register
Address  in  16  data-memory address for load/store
storeData  in  16  store data
readEnable  in  1  load request (p3 memWrite==1)
writeEnable  in  1  store request (p3 memWrite==2)
memRdata  in  16  read data from data memory, valid with memReady
memReady  in  1  memory completes the current access this cycle
memAddr  out  16  address to data memory
memWdata  out  16  write data to data memory
memRead  out  1  read strobe, held until memReady
memWrite  out  1  write strobe, held until memReady
stall  out  1  freeze upstream stages and hold p3 outputs
memError  out  1  one-cycle pulse on timeout abort or an illegal read+write request
writeRegp4  out  1  register-file write enable
regAddressp4  out  3  register-file write address
writeDatap4  out  16  register-file write data

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0. Timeout counter 0. An outstanding access is dropped immediately: memRead/memWrite fall without waiting for memReady.
- States:
  - IDLE: no access outstanding.
  - ACCESS: request held on the memory port.
- IDLE, readEnable=0 and writeEnable=0 (ALU op):
  - Next edge: writeDatap4<=aluOutput, writeRegp4<=writeRegp3, regAddressp4<=regAddressp3.
  - Latency 1 cycle; state stays IDLE.
- IDLE, readEnable=1 or writeEnable=1:
  - Next edge: capture Address, storeData, regAddressp3 and request type into holding registers; state<=ACCESS; counter<=0; writeRegp4<=0 (bubble).
- readEnable=1 and writeEnable=1 together is illegal: treated as a read, memError pulses for one cycle.
- ACCESS outputs:
  - memAddr and memWdata come from the holding registers.
  - memRead or memWrite is 1 per the captured type.
  - stall=1, combinational from state. Upstream inputs are ignored while in ACCESS.
  - writeRegp4=0 in every ACCESS cycle.
- ACCESS, memReady=1 at an edge:
  - Load: writeDatap4<=memRdata, writeRegp4<=1, regAddressp4<=captured register.
  - Store: writeRegp4<=0. A store never writes the register file, even if writeRegp3 was 1.
  - state<=IDLE; stall and strobes drop the following cycle.
  - Minimum access = 2 cycles from request acceptance to write-back.
- ACCESS, memReady=0: counter increments. When the counter reaches TIMEOUT-1 and memReady is still 0:
  - state<=IDLE, memError pulses 1 cycle, writeRegp4<=0.
  - Load data is discarded; no register write occurs.
- memReady while IDLE is ignored.
- Back-to-back: the first cycle after returning to IDLE samples p3 normally. A new load/store can be accepted there, so at most 1 idle cycle separates accesses.
- Simultaneous memReady and timeout at the same edge: memReady wins, normal completion, no memError.
- writeDatap4 holds its last value whenever writeRegp4=0.
- stall=0 in IDLE, including during reset.

Decomposition:
- simple_pkg holds:
  - state encoding (IDLE=0, ACCESS=1);
  - DATA_W=16 and REG_W=3 constants;
  - memWrite code constants (MEM_NONE=0, MEM_READ=1, MEM_WRITE=2), shared with p3.
- No sub-module is needed. The timeout counter is inline; p4_timer is the only natural split and is optional.

Test Plan:
- ALU passthrough: aluOutput=16'h1234, writeRegp3=1, regAddressp3=5, no mem -> next cycle writeRegp4=1, regAddressp4=5, writeDatap4=16'h1234, stall=0.
- Load, 3-cycle memory: readEnable=1, Address=16'h0040, regAddressp3=2, memReady high on the 3rd ACCESS cycle with memRdata=16'hBEEF -> memRead=1, memAddr=16'h0040, stall=1 for 3 cycles; then writeRegp4=1, regAddressp4=2, writeDatap4=16'hBEEF.
- Store with writeRegp3=1: writeEnable=1, Address=16'h0010, storeData=16'h00AA, memReady next cycle -> memWrite=1, memWdata=16'h00AA for 1 cycle, writeRegp4 stays 0.
- Timeout: TIMEOUT=4, load with memReady tied 0 -> stall=1 exactly 4 cycles, then memError=1 for 1 cycle, writeRegp4=0, state IDLE.
- Reset mid-access: pull rst_n low in the 2nd ACCESS cycle -> memRead, stall, writeRegp4 all 0 immediately (before next edge); after release, an ALU op passes with 1-cycle latency.
- Illegal request: readEnable=writeEnable=1 -> memError pulse, memRead=1, memWrite=0.
